// File: rtl/pragmatic_pkg.sv
// Shared types and constants for the 16-lane Pragmatic bit-serial MAC sequencer.
package pragmatic_pkg;

    localparam int LANES   = 16;
    localparam int W_WIDTH = 8;
    localparam int SH1_MAX = 3;

    typedef logic [1:0] sh1_t;
    typedef logic [2:0] sh2_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Magnitude of a two's complement weight; -128 keeps its 0x80 pattern.
    function automatic logic [W_WIDTH-1:0] abs_mag(input logic [W_WIDTH-1:0] w);
        logic [W_WIDTH-1:0] m;
        if (w[W_WIDTH-1]) begin
            m = ~w + {{(W_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = w;
        end
        return m;
    endfunction

endpackage

// File: rtl/pragmatic_lane_pick.sv
// Per-lane essential-bit picker: finds the lowest remaining set bit and decides
// whether it falls inside the first-stage shift window above the shared base.
module pragmatic_lane_pick
    import pragmatic_pkg::*;
(
    input  logic [W_WIDTH-1:0] rem,
    input  sh2_t               base,
    output sh2_t               p,
    output logic               v,
    output logic               fire,
    output sh1_t               sel,
    output logic [W_WIDTH-1:0] rem_next
);

    sh2_t diff_s;

    // Lowest set bit of the remaining magnitude (descending scan keeps the minimum)
    always_comb begin
        p = 3'd0;
        for (int i = W_WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) begin
                p = 3'(i);
            end else begin
                p = p;
            end
        end
    end

    // Window test against the base and clearing of the consumed bit
    always_comb begin
        v        = (rem != {W_WIDTH{1'b0}});
        diff_s   = p - base;
        fire     = v && (diff_s <= sh2_t'(SH1_MAX));
        sel      = 2'd0;
        rem_next = rem;
        if (fire) begin
            sel         = diff_s[1:0];
            rem_next[p] = 1'b0;
        end else begin
            sel      = 2'd0;
            rem_next = rem;
        end
    end

endmodule

// File: rtl/pragmatic_sched_16.sv
// Job sequencer for the 16-lane Pragmatic MAC: decomposes weights into set bits,
// issues shift/sign controls per cycle, then a drain cycle and an acc_valid pulse.
module pragmatic_sched_16
    import pragmatic_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_first,
    input  logic [LANES-1:0][W_WIDTH-1:0]    cmd_w,
    output logic                             mac_en,
    output logic                             load_accum,
    output logic [LANES-1:0][1:0]            shift_1st_sel,
    output logic [LANES-1:0]                 shift_1st_en,
    output logic [LANES-1:0]                 is_neg,
    output logic [2:0]                       shift_2nd_sel,
    output logic                             shift_2nd_en,
    output logic                             acc_valid,
    output logic                             busy
);

    state_t               state_r, state_nxt_s;
    logic [W_WIDTH-1:0]   rem_r      [LANES];
    logic [LANES-1:0]     sgn_r;

    logic                 accept_s;
    logic [W_WIDTH-1:0]   pick_in_s  [LANES];
    logic [LANES-1:0]     sgn_in_s;
    sh2_t                 p_s        [LANES];
    logic                 v_s        [LANES];
    logic                 fire_s     [LANES];
    sh1_t                 sel_s      [LANES];
    logic [W_WIDTH-1:0]   rem_pick_s [LANES];
    sh2_t                 base_s;
    logic                 any_fire_s;
    logic                 rem_zero_s;

    logic                 issue_s;
    logic [W_WIDTH-1:0]   rem_nxt_s  [LANES];
    logic [LANES-1:0]     sgn_nxt_s;
    logic                 mac_en_nxt_s, load_nxt_s, acc_nxt_s, busy_nxt_s, ready_nxt_s;
    logic [LANES-1:0][1:0] sel_nxt_s;
    logic [LANES-1:0]     en_nxt_s, neg_nxt_s;
    sh2_t                 sh2_nxt_s;
    logic                 sh2_en_nxt_s;

    // Outputs are registered, so the picker looks at the bits of the cycle being
    // entered: the new job's weights on accept, otherwise the stored remainder.
    always_comb begin
        accept_s   = cmd_valid && cmd_ready;
        rem_zero_s = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            if (accept_s) begin
                pick_in_s[j] = abs_mag(cmd_w[j]);
                sgn_in_s[j]  = cmd_w[j][W_WIDTH-1];
            end else begin
                pick_in_s[j] = rem_r[j];
                sgn_in_s[j]  = sgn_r[j];
            end
            rem_zero_s = rem_zero_s && (rem_r[j] == {W_WIDTH{1'b0}});
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        pragmatic_lane_pick u_pick (
            .rem      (pick_in_s[j]),
            .base     (base_s),
            .p        (p_s[j]),
            .v        (v_s[j]),
            .fire     (fire_s[j]),
            .sel      (sel_s[j]),
            .rem_next (rem_pick_s[j])
        );
    end

    // Shared base: minimum lowest-set-bit over lanes with work left, 0 if none
    always_comb begin
        logic any_v;
        sh2_t min_p;
        any_v = 1'b0;
        min_p = 3'd7;
        for (int j = 0; j < LANES; j++) begin
            if (v_s[j] && (p_s[j] < min_p)) begin
                min_p = p_s[j];
            end else begin
                min_p = min_p;
            end
            any_v = any_v || v_s[j];
        end
        base_s = any_v ? min_p : 3'd0;
    end

    // Any lane firing enables the second-stage shifter
    always_comb begin
        any_fire_s = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            any_fire_s = any_fire_s || fire_s[j];
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s  = state_r;
        issue_s      = 1'b0;
        load_nxt_s   = 1'b0;
        acc_nxt_s    = 1'b0;
        mac_en_nxt_s = 1'b0;
        sel_nxt_s    = {(2*LANES){1'b0}};
        en_nxt_s     = {LANES{1'b0}};
        neg_nxt_s    = {LANES{1'b0}};
        sh2_nxt_s    = 3'd0;
        sh2_en_nxt_s = 1'b0;
        sgn_nxt_s    = sgn_r;
        for (int j = 0; j < LANES; j++) begin
            rem_nxt_s[j] = rem_r[j];
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    issue_s    = 1'b1;
                    load_nxt_s = cmd_first;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COMPUTE: begin
                if (rem_zero_s) begin
                    state_nxt_s  = DRAIN;
                    mac_en_nxt_s = 1'b1;
                end else begin
                    issue_s = 1'b1;
                end
            end
            DRAIN: begin
                acc_nxt_s = 1'b1;
                if (accept_s) begin
                    issue_s    = 1'b1;
                    load_nxt_s = cmd_first;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (issue_s) begin
            state_nxt_s  = COMPUTE;
            mac_en_nxt_s = 1'b1;
            sh2_nxt_s    = base_s;
            sh2_en_nxt_s = any_fire_s;
            for (int j = 0; j < LANES; j++) begin
                sel_nxt_s[j] = sel_s[j];
                en_nxt_s[j]  = fire_s[j];
                neg_nxt_s[j] = fire_s[j] && sgn_in_s[j];
                rem_nxt_s[j] = rem_pick_s[j];
                sgn_nxt_s[j] = sgn_in_s[j];
            end
        end else begin
            sh2_nxt_s = 3'd0;
        end

        busy_nxt_s  = (state_nxt_s != IDLE);
        ready_nxt_s = (state_nxt_s != COMPUTE);
    end

    // State, remainder and registered output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            sgn_r         <= {LANES{1'b0}};
            for (int j = 0; j < LANES; j++) begin
                rem_r[j] <= {W_WIDTH{1'b0}};
            end
            cmd_ready     <= 1'b1;
            mac_en        <= 1'b0;
            load_accum    <= 1'b0;
            shift_1st_sel <= {(2*LANES){1'b0}};
            shift_1st_en  <= {LANES{1'b0}};
            is_neg        <= {LANES{1'b0}};
            shift_2nd_sel <= 3'd0;
            shift_2nd_en  <= 1'b0;
            acc_valid     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            sgn_r         <= sgn_nxt_s;
            for (int j = 0; j < LANES; j++) begin
                rem_r[j] <= rem_nxt_s[j];
            end
            cmd_ready     <= ready_nxt_s;
            mac_en        <= mac_en_nxt_s;
            load_accum    <= load_nxt_s;
            shift_1st_sel <= sel_nxt_s;
            shift_1st_en  <= en_nxt_s;
            is_neg        <= neg_nxt_s;
            shift_2nd_sel <= sh2_nxt_s;
            shift_2nd_en  <= sh2_en_nxt_s;
            acc_valid     <= acc_nxt_s;
            busy          <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_pragmatic_sched_16.sv
// Self-checking bench for pragmatic_sched_16: cycle-level scoreboard plus
// table-driven job vectors and hand-written back-to-back / reset sequences.
module tb_pragmatic_sched_16;
    import pragmatic_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_first;
    logic [LANES-1:0][W_WIDTH-1:0] cmd_w;
    logic mac_en, load_accum;
    logic [LANES-1:0][1:0] shift_1st_sel;
    logic [LANES-1:0] shift_1st_en, is_neg;
    logic [2:0] shift_2nd_sel;
    logic shift_2nd_en, acc_valid, busy;

    always #5 clk = ~clk;

    pragmatic_sched_16 dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_first(cmd_first), .cmd_w(cmd_w), .mac_en(mac_en), .load_accum(load_accum),
        .shift_1st_sel(shift_1st_sel), .shift_1st_en(shift_1st_en), .is_neg(is_neg),
        .shift_2nd_sel(shift_2nd_sel), .shift_2nd_en(shift_2nd_en),
        .acc_valid(acc_valid), .busy(busy)
    );

    typedef struct packed {
        logic                  mac_en;
        logic                  load_accum;
        logic [LANES-1:0][1:0] sel;
        logic [LANES-1:0]      en;
        logic [LANES-1:0]      neg;
        logic [2:0]            sh2;
        logic                  sh2_en;
        logic                  acc_valid;
        logic                  busy;
        logic                  ready;
    } outs_t;

    typedef struct {
        logic [LANES-1:0][W_WIDTH-1:0] w;
        logic first;
        int   ncyc;
        int   sum;
        int   b_first;
        int   b_last;
    } vec_t;

    outs_t exp_q[$];
    outs_t m_out;
    int    m_state;
    logic [7:0] m_rem [LANES];
    logic [LANES-1:0] m_sgn;
    logic  last_acc;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int obs_sum = 0, obs_cycles = 0, obs_b_first = 0, obs_b_last = 0;
    logic obs_load_first;
    int done_cnt = 0, done_sum = 0, done_cycles = 0, done_b_first = 0, done_b_last = 0;
    logic done_load_first;

    vec_t vecs[10];

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: computes expected outputs of the cycle after this edge.
    task automatic model_edge(input logic acc, input logic first,
                              input logic [LANES-1:0][W_WIDTH-1:0] w);
        outs_t o;
        int nxt, base, lb, s;
        logic issue;
        o = '0;
        nxt = m_state;
        issue = 1'b0;
        if (reset) begin
            nxt = 0;
            for (int j = 0; j < LANES; j++) m_rem[j] = 8'h00;
        end else begin
            case (m_state)
                0: if (acc) begin issue = 1'b1; o.load_accum = first; end
                1: begin
                    nxt = 2;
                    for (int j = 0; j < LANES; j++) if (m_rem[j] != 8'h00) begin nxt = 1; issue = 1'b1; end
                end
                default: begin
                    o.acc_valid = 1'b1;
                    if (acc) begin issue = 1'b1; o.load_accum = first; end
                    else nxt = 0;
                end
            endcase
            if (issue && m_state != 1) begin
                for (int j = 0; j < LANES; j++) begin
                    s = int'(signed'(w[j]));
                    m_rem[j] = 8'((s < 0) ? -s : s);
                    m_sgn[j] = (s < 0);
                end
            end
            if (issue) begin
                nxt = 1;
                base = 0;
                for (int b = 7; b >= 0; b--)
                    for (int j = 0; j < LANES; j++) if (m_rem[j][b]) base = b;
                for (int j = 0; j < LANES; j++) begin
                    if (m_rem[j] != 8'h00) begin
                        lb = 0;
                        for (int b = 7; b >= 0; b--) if (m_rem[j][b]) lb = b;
                        if (lb - base <= 3) begin
                            o.en[j]  = 1'b1;
                            o.sel[j] = 2'(lb - base);
                            o.neg[j] = m_sgn[j];
                            m_rem[j][lb] = 1'b0;
                        end
                    end
                end
                o.sh2 = 3'(base);
                o.sh2_en = |o.en;
            end
        end
        o.mac_en = (nxt != 0);
        o.busy   = (nxt != 0);
        o.ready  = (nxt != 1);
        m_state  = nxt;
        m_out    = o;
        exp_q.push_back(o);
    endtask

    task automatic check_cycle();
        outs_t got, exp;
        int val;
        got = {mac_en, load_accum, shift_1st_sel, shift_1st_en, is_neg,
               shift_2nd_sel, shift_2nd_en, acc_valid, busy, cmd_ready};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at cycle %0d", cyc_no);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_outputs at cycle %0d: got %h expected %h", cyc_no, got, exp);
            end
        end
        if (acc_valid) begin
            done_sum = obs_sum; done_cycles = obs_cycles;
            done_b_first = obs_b_first; done_b_last = obs_b_last;
            done_load_first = obs_load_first;
            done_cnt++;
            obs_sum = 0; obs_cycles = 0;
        end
        if (mac_en && !cmd_ready) begin
            if (obs_cycles == 0) begin
                obs_b_first = int'(shift_2nd_sel);
                obs_load_first = load_accum;
            end
            obs_b_last = int'(shift_2nd_sel);
            obs_cycles++;
            for (int j = 0; j < LANES; j++) begin
                if (shift_1st_en[j]) begin
                    val = 1 << (int'(shift_1st_sel[j]) + int'(shift_2nd_sel));
                    obs_sum += is_neg[j] ? -val : val;
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input logic f, input logic [LANES-1:0][W_WIDTH-1:0] w);
        cmd_valid = v;
        cmd_first = f;
        cmd_w     = w;
        last_acc  = v && m_out.ready && !reset;
        model_edge(last_acc, f, w);
        @(negedge clk);
        cyc_no++;
        check_cycle();
    endtask

    task automatic run_job(input vec_t vv, input string name);
        int start;
        start = done_cnt;
        cyc(1'b1, vv.first, vv.w);
        for (int k = 0; k < 40 && done_cnt == start; k++) cyc(1'b0, 1'b0, '0);
        checks++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL %s_timeout: got no acc_valid expected one within 40 cycles", name);
        end else begin
            cmp({name, "_cycles"}, done_cycles, vv.ncyc);
            cmp({name, "_sum"}, done_sum, vv.sum);
            cmp({name, "_base_first"}, done_b_first, vv.b_first);
            cmp({name, "_base_last"}, done_b_last, vv.b_last);
            cmp({name, "_load"}, int'(done_load_first), int'(vv.first));
        end
    endtask

    initial begin
        logic [LANES-1:0][W_WIDTH-1:0] w7;
        int start, acc_seen;
        m_state = 0;
        m_out = '0;
        for (int j = 0; j < LANES; j++) m_rem[j] = 8'h00;
        m_sgn = '0;
        obs_load_first = 1'b0;
        done_load_first = 1'b0;

        for (int i = 0; i < 10; i++) begin
            vecs[i].w = '0; vecs[i].first = 1'b1;
        end
        vecs[0].w[0] = 8'h05; vecs[0].w[1] = 8'hFD;
        vecs[0].ncyc = 2; vecs[0].sum = 2;    vecs[0].b_first = 0; vecs[0].b_last = 1;
        vecs[1].w[0] = 8'h01; vecs[1].w[1] = 8'h10;
        vecs[1].ncyc = 2; vecs[1].sum = 17;   vecs[1].b_first = 0; vecs[1].b_last = 4;
        vecs[2].w[0] = 8'h01; vecs[2].w[1] = 8'h08; vecs[2].first = 1'b0;
        vecs[2].ncyc = 1; vecs[2].sum = 9;    vecs[2].b_first = 0; vecs[2].b_last = 0;
        vecs[3].w[0] = 8'h80;
        vecs[3].ncyc = 1; vecs[3].sum = -128; vecs[3].b_first = 7; vecs[3].b_last = 7;
        vecs[4].w[0] = 8'h01; vecs[4].w[1] = 8'h80;
        vecs[4].ncyc = 2; vecs[4].sum = -127; vecs[4].b_first = 0; vecs[4].b_last = 7;
        vecs[5].w[0] = 8'h7F; vecs[5].first = 1'b0;
        vecs[5].ncyc = 7; vecs[5].sum = 127;  vecs[5].b_first = 0; vecs[5].b_last = 6;
        vecs[6].ncyc = 1; vecs[6].sum = 0;    vecs[6].b_first = 0; vecs[6].b_last = 0;
        for (int j = 0; j < LANES; j++) vecs[7].w[j] = 8'(j);
        vecs[7].ncyc = 4; vecs[7].sum = 120;  vecs[7].b_first = 0; vecs[7].b_last = 3;
        for (int j = 0; j < LANES; j++) vecs[8].w[j] = 8'hFF;
        vecs[8].first = 1'b0;
        vecs[8].ncyc = 1; vecs[8].sum = -16;  vecs[8].b_first = 0; vecs[8].b_last = 0;
        vecs[9].w[0] = 8'h11; vecs[9].w[1] = 8'h01; vecs[9].first = 1'b0;
        vecs[9].ncyc = 2; vecs[9].sum = 18;   vecs[9].b_first = 0; vecs[9].b_last = 4;

        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cmp("reset_ready", int'(cmd_ready), 1);
        cmp("reset_busy", int'(busy), 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, '0);

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
            cyc(1'b0, 1'b0, '0);
        end

        // Back-to-back: second job offered throughout the first; taken in DRAIN
        cyc(1'b1, 1'b1, vecs[0].w);
        acc_seen = 0;
        for (int k = 0; k < 20 && acc_seen == 0; k++) begin
            cyc(1'b1, 1'b1, vecs[7].w);
            if (last_acc) acc_seen = 1;
        end
        cmp("b2b_accepted", acc_seen, 1);
        cmp("b2b_overlap", int'({acc_valid, busy, cmd_ready, mac_en}), 'b1101);
        cmp("b2b_first_sum", done_sum, 2);
        start = done_cnt;
        for (int k = 0; k < 20 && done_cnt == start; k++) cyc(1'b0, 1'b0, '0);
        cmp("b2b_second_sum", done_sum, 120);
        cmp("b2b_second_cycles", done_cycles, 4);
        cyc(1'b0, 1'b0, '0);

        // Reset in the second COMPUTE cycle of a three-cycle job
        w7 = '0;
        w7[0] = 8'h07;
        cyc(1'b1, 1'b1, w7);
        cyc(1'b0, 1'b0, '0);
        cmp("abort_in_compute", int'({busy, cmd_ready}), 'b10);
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        reset = 1'b0;
        cmp("abort_idle", int'({busy, mac_en, cmd_ready, acc_valid}), 'b0010);
        obs_sum = 0; obs_cycles = 0;
        start = done_cnt;
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, '0);
        cmp("abort_no_acc_valid", done_cnt, start);
        run_job(vecs[1], "after_abort");
        cyc(1'b0, 1'b0, '0);

        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
